// File: rtl/parity_stream_unit.sv
// Streaming parity generator/checker with one registered valid/ready stage.
// Also tracks link health with a saturating error counter and a sticky error flag.
module parity_stream_unit #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    input  logic              in_odd,
    input  logic              in_chk_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_parity,
    output logic              out_err,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_sticky
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_parity;
    logic              r_err;
    logic [CNT_W-1:0]  r_count;
    logic              r_sticky;

    logic              w_accept;
    logic              w_take;
    logic              w_gen;
    logic              w_err;
    logic              w_err_accept;
    logic              w_valid_d;
    logic [CNT_W-1:0]  w_count_d;
    logic              w_sticky_d;

    // Ready whenever the stage is empty or is being drained this cycle.
    assign in_ready     = !r_valid || out_ready;
    assign w_accept     = in_valid && in_ready;
    assign w_take       = r_valid && out_ready;
    assign w_gen        = (^in_data) ^ in_odd;
    assign w_err        = in_chk_en && (in_parity != w_gen);
    assign w_err_accept = w_accept && w_err;

    always_comb begin
        w_valid_d = r_valid;
        if (w_accept) begin
            w_valid_d = 1'b1;
        end else if (w_take) begin
            w_valid_d = 1'b0;
        end
    end

    // Clear takes priority, but an error in the same cycle is still counted.
    always_comb begin
        w_count_d  = r_count;
        w_sticky_d = r_sticky;
        if (clr_err) begin
            w_count_d  = w_err_accept ? CNT_W'(1) : '0;
            w_sticky_d = w_err_accept;
        end else if (w_err_accept) begin
            w_sticky_d = 1'b1;
            if (r_count != {CNT_W{1'b1}}) begin
                w_count_d = r_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_parity <= 1'b0;
            r_err    <= 1'b0;
            r_count  <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_valid  <= w_valid_d;
            r_count  <= w_count_d;
            r_sticky <= w_sticky_d;
            if (w_accept) begin
                r_data   <= in_data;
                r_parity <= w_gen;
                r_err    <= w_err;
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign out_parity = r_parity;
    assign out_err    = r_err;
    assign err_count  = r_count;
    assign err_sticky = r_sticky;

endmodule
